// File: rtl/t01_game_pkg.sv
// Shared game constants and the drop scheduler state encoding.
// Imported by the scheduler, its interface and its period calculator.
package t01_game_pkg;

    localparam logic [3:0] GS_PLAY    = 4'd2;
    localparam logic [3:0] GS_RESTART = 4'd9;

    typedef enum logic [1:0] {
        IDLE,
        FALLING,
        LOCKING,
        LOCKED
    } sched_state_t;

endpackage

// File: rtl/t01_drop_scheduler_if.sv
// Signal bundle between game/board logic and the drop scheduler.
// The scheduler takes the slave side; game/board logic drives the master side.
interface t01_drop_scheduler_if;
    import t01_game_pkg::*;

    logic [3:0]   gamestate;
    logic [24:0]  scoremod;
    logic         soft_drop;
    logic         landed;
    logic         piece_moved;
    logic         drop_tick;
    logic         lock_pulse;
    logic [24:0]  period_out;
    sched_state_t sched_state;

    modport master (
        output gamestate, scoremod, soft_drop, landed, piece_moved,
        input  drop_tick, lock_pulse, period_out, sched_state
    );

    modport slave (
        input  gamestate, scoremod, soft_drop, landed, piece_moved,
        output drop_tick, lock_pulse, period_out, sched_state
    );

endinterface

// File: rtl/t01_period_calc.sv
// Gravity period from the speed modifier, clamped at the floor,
// with soft drop taking over only when it is faster.
module t01_period_calc #(
    parameter logic [24:0] BASE_PERIOD = 25'd25_000_000,
    parameter logic [24:0] MIN_PERIOD  = 25'd2_000_000,
    parameter logic [24:0] SOFT_PERIOD = 25'd1_000_000
) (
    input  logic [24:0] scoremod,
    input  logic        soft_drop,
    output logic [24:0] per
);
    logic [25:0] sum;
    logic [24:0] eff;

    // 26-bit sum so a saturated modifier cannot wrap below the base
    always_comb begin
        sum = {1'b0, scoremod} + {1'b0, MIN_PERIOD};
        eff = (sum < {1'b0, BASE_PERIOD}) ? BASE_PERIOD - scoremod
                                          : MIN_PERIOD;
        per = (soft_drop && (SOFT_PERIOD < eff)) ? SOFT_PERIOD : eff;
    end

endmodule

// File: rtl/t01_drop_scheduler.sv
// Gravity tick generator and lock-delay state machine for the
// falling piece; freezes while the game is paused.
module t01_drop_scheduler
    import t01_game_pkg::*;
#(
    parameter logic [24:0] BASE_PERIOD = 25'd25_000_000,
    parameter logic [24:0] MIN_PERIOD  = 25'd2_000_000,
    parameter logic [24:0] SOFT_PERIOD = 25'd1_000_000,
    parameter logic [24:0] LOCK_DELAY  = 25'd12_500_000,
    parameter logic [3:0]  MAX_RESETS  = 4'd15
) (
    input logic                 clk,
    input logic                 reset,
    t01_drop_scheduler_if.slave bus
);
    sched_state_t state_q, state_d;
    logic [24:0]  gcnt_q, gcnt_d;
    logic [24:0]  lcnt_q, lcnt_d;
    logic [3:0]   rused_q, rused_d;
    logic         tick_q, tick_d;
    logic         lock_q, lock_d;
    logic [24:0]  per_q, per_d;
    logic [24:0]  per;
    logic         play, restart, g_exp, l_exp, honored;

    t01_period_calc #(
        .BASE_PERIOD(BASE_PERIOD),
        .MIN_PERIOD (MIN_PERIOD),
        .SOFT_PERIOD(SOFT_PERIOD)
    ) u_period (
        .scoremod (bus.scoremod),
        .soft_drop(bus.soft_drop),
        .per      (per)
    );

    assign play    = (bus.gamestate == GS_PLAY);
    assign restart = (bus.gamestate == GS_RESTART);
    assign g_exp   = (gcnt_q >= per - 25'd1);
    assign l_exp   = (lcnt_q >= LOCK_DELAY - 25'd1);
    assign honored = bus.piece_moved && (rused_q < MAX_RESETS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            gcnt_q  <= '0;
            lcnt_q  <= '0;
            rused_q <= '0;
            tick_q  <= 1'b0;
            lock_q  <= 1'b0;
            per_q   <= BASE_PERIOD;
        end else begin
            state_q <= state_d;
            gcnt_q  <= gcnt_d;
            lcnt_q  <= lcnt_d;
            rused_q <= rused_d;
            tick_q  <= tick_d;
            lock_q  <= lock_d;
            per_q   <= per_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gcnt_d  = gcnt_q;
        lcnt_d  = lcnt_q;
        rused_d = rused_q;
        if (restart) begin
            state_d = IDLE;
            gcnt_d  = '0;
            lcnt_d  = '0;
            rused_d = '0;
        end else if (play) begin
            unique case (state_q)
                IDLE: begin
                    state_d = FALLING;
                    gcnt_d  = '0;
                end
                FALLING: begin
                    if (bus.landed) begin
                        state_d = LOCKING;
                        lcnt_d  = '0;
                        gcnt_d  = '0;
                    end else if (g_exp) begin
                        gcnt_d = '0;
                    end else begin
                        gcnt_d = gcnt_q + 25'd1;
                    end
                end
                LOCKING: begin
                    // slide-off outranks moves; an honoured move outranks expiry
                    if (!bus.landed) begin
                        state_d = FALLING;
                        gcnt_d  = '0;
                    end else if (honored) begin
                        lcnt_d  = '0;
                        rused_d = rused_q + 4'd1;
                    end else if (l_exp) begin
                        state_d = LOCKED;
                    end else begin
                        lcnt_d = lcnt_q + 25'd1;
                    end
                end
                LOCKED: begin
                    state_d = FALLING;
                    gcnt_d  = '0;
                    rused_d = '0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        tick_d = play && (state_q == FALLING) && !bus.landed && g_exp;
        lock_d = play && (state_q == LOCKING) && bus.landed
                 && !honored && l_exp;
        per_d  = per_q;
        if (restart)
            per_d = BASE_PERIOD;
        else if (play)
            per_d = per;
    end

    assign bus.drop_tick   = tick_q;
    assign bus.lock_pulse  = lock_q;
    assign bus.period_out  = per_q;
    assign bus.sched_state = state_q;

endmodule

// File: tb/tb_t01_drop_scheduler.sv
// Directed bench for the drop scheduler with shortened timing
// (BASE=100, MIN=20, SOFT=5, LOCK_DELAY=30, MAX_RESETS=3).
module tb_t01_drop_scheduler;
    import t01_game_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int tests = 0;
    int fails = 0;
    int n;
    int pulses;

    logic [24:0] sm30;
    logic        sd30;
    logic [24:0] per30;

    t01_drop_scheduler_if bus ();

    t01_drop_scheduler #(
        .BASE_PERIOD(25'd100),
        .MIN_PERIOD (25'd20),
        .SOFT_PERIOD(25'd5),
        .LOCK_DELAY (25'd30),
        .MAX_RESETS (4'd3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    t01_period_calc #(
        .BASE_PERIOD(25'd100),
        .MIN_PERIOD (25'd20),
        .SOFT_PERIOD(25'd30)
    ) pc30 (
        .scoremod (sm30),
        .soft_drop(sd30),
        .per      (per30)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // counts falling edges until drop_tick; exp < 0 only requires a tick
    task automatic wait_tick(input string tag, input int exp,
                             input int maxc);
        int k;
        for (k = 1; k <= maxc; k++) begin
            @(negedge clk);
            if (bus.drop_tick) break;
        end
        if (exp < 0)
            check(tag, (k <= maxc) ? 32'd1 : 32'd0, 32'd1);
        else
            check(tag, k, exp);
    endtask

    task automatic wait_lock(input string tag, input int exp,
                             input int move_at);
        int k;
        for (k = 1; k <= 80; k++) begin
            @(negedge clk);
            bus.piece_moved = (k == move_at);
            if (bus.lock_pulse) break;
        end
        bus.piece_moved = 1'b0;
        check(tag, k, exp);
    endtask

    initial begin
        reset           = 1'b1;
        bus.gamestate   = GS_PLAY;
        bus.scoremod    = '0;
        bus.soft_drop   = 1'b0;
        bus.landed      = 1'b0;
        bus.piece_moved = 1'b0;
        sm30            = '0;
        sd30            = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_state", bus.sched_state, IDLE);
        check("rst_tick", bus.drop_tick, 0);
        check("rst_lock", bus.lock_pulse, 0);
        check("rst_period", bus.period_out, 100);
        reset = 1'b0;

        wait_tick("first_tick", 101, 300);
        check("fall_state", bus.sched_state, FALLING);
        check("base_period", bus.period_out, 100);
        wait_tick("base_tick", 100, 300);

        bus.scoremod = 25'd50;
        wait_tick("mod50_tick", 50, 300);
        check("mod50_period", bus.period_out, 50);
        bus.scoremod = 25'd90;
        wait_tick("mod90_tick", 20, 300);
        check("mod90_period", bus.period_out, 20);
        bus.scoremod = 25'h1FF_FFFF;
        wait_tick("modmax_tick", 20, 300);
        check("modmax_period", bus.period_out, 20);

        bus.scoremod = '0;
        repeat (40) @(negedge clk);
        bus.soft_drop = 1'b1;
        wait_tick("soft_mid", 1, 10);
        wait_tick("soft_tick", 5, 20);
        check("soft_period", bus.period_out, 5);
        bus.scoremod = 25'd97;
        @(negedge clk);
        check("soft97_period", bus.period_out, 5);

        sm30 = 25'd97;
        sd30 = 1'b1;
        #1 check("soft30_slower", per30, 20);
        sm30 = 25'd0;
        #1 check("soft30_faster", per30, 30);

        bus.soft_drop = 1'b0;
        bus.scoremod  = '0;
        wait_tick("resync", -1, 300);

        repeat (99) @(negedge clk);
        bus.landed = 1'b1;
        @(negedge clk);
        check("land_no_tick", bus.drop_tick, 0);
        check("land_state", bus.sched_state, LOCKING);
        for (int r = 0; r < 3; r++) begin
            repeat (25) @(negedge clk);
            bus.piece_moved = 1'b1;
            @(negedge clk);
            bus.piece_moved = 1'b0;
        end
        check("resets_state", bus.sched_state, LOCKING);
        wait_lock("lock_after_resets", 30, 25);
        check("locked_state", bus.sched_state, LOCKED);
        bus.landed = 1'b0;
        @(negedge clk);
        check("post_lock_state", bus.sched_state, FALLING);
        check("post_lock_pulse", bus.lock_pulse, 0);
        wait_tick("post_lock_tick", 100, 300);

        repeat (5) @(negedge clk);
        bus.landed = 1'b1;
        repeat (10) @(negedge clk);
        check("slide_locking", bus.sched_state, LOCKING);
        bus.landed = 1'b0;
        @(negedge clk);
        check("slide_state", bus.sched_state, FALLING);
        wait_tick("slide_tick", 100, 300);

        bus.landed = 1'b1;
        @(negedge clk);
        repeat (29) @(negedge clk);
        bus.piece_moved = 1'b1;
        @(negedge clk);
        bus.piece_moved = 1'b0;
        check("collide_nolock", bus.lock_pulse, 0);
        check("collide_state", bus.sched_state, LOCKING);
        wait_lock("collide_lock", 30, 0);
        bus.landed = 1'b0;
        @(negedge clk);

        wait_tick("pre_pause", -1, 300);
        repeat (60) @(negedge clk);
        bus.gamestate = 4'd5;
        bus.scoremod  = 25'd50;
        pulses = 0;
        repeat (500) begin
            @(negedge clk);
            if (bus.drop_tick || bus.lock_pulse) pulses++;
        end
        check("pause_pulses", pulses, 0);
        check("pause_period", bus.period_out, 100);
        check("pause_state", bus.sched_state, FALLING);
        bus.gamestate = GS_PLAY;
        bus.scoremod  = '0;
        wait_tick("resume_tick", 40, 100);

        bus.landed   = 1'b1;
        bus.scoremod = 25'd50;
        repeat (5) @(negedge clk);
        check("pre_restart_state", bus.sched_state, LOCKING);
        check("pre_restart_period", bus.period_out, 50);
        bus.gamestate = GS_RESTART;
        @(negedge clk);
        check("restart_state", bus.sched_state, IDLE);
        check("restart_period", bus.period_out, 100);
        bus.gamestate = GS_PLAY;
        bus.landed    = 1'b0;
        bus.scoremod  = '0;
        wait_tick("restart_tick", 101, 300);

        bus.scoremod = 25'd50;
        wait_tick("pre_async", -1, 300);
        check("pre_async_period", bus.period_out, 50);
        #1 reset = 1'b1;
        #1;
        check("async_tick", bus.drop_tick, 0);
        check("async_state", bus.sched_state, IDLE);
        check("async_period", bus.period_out, 100);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/t01_drop_scheduler.md
Name: t01_drop_scheduler

Overview:
- Sequences piece gravity for the falling-block game.
- Converts the score-driven speed modifier `scoremod` into an effective drop period, and emits one-cycle `drop_tick` pulses.
- Runs the lock-delay state machine: piece landed -> grace timer with limited move resets -> `lock_pulse`.
- Sits between the speed controller (source of `scoremod`) and the board/piece logic (consumer of `drop_tick` and `lock_pulse`).

Parameters:
- BASE_PERIOD, 25'd25_000_000, drop period in clk cycles at `scoremod` = 0.
- MIN_PERIOD, 25'd2_000_000, floor on the effective gravity period.
- SOFT_PERIOD, 25'd1_000_000, period while `soft_drop` is held (used only if smaller than the effective period).
- LOCK_DELAY, 25'd12_500_000, cycles from landing to lock.
- MAX_RESETS, 4'd15, maximum lock-timer restarts per piece.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- gamestate  in  4  game FSM state; encodings from t01_game_pkg
- scoremod  in  25  cumulative speed-up from the speed controller
- soft_drop  in  1  player holding down, level-sensitive
- landed  in  1  piece resting on stack/floor, level-sensitive
- piece_moved  in  1  one-cycle pulse, successful shift/rotate
- drop_tick  out  1  one-cycle gravity pulse
- lock_pulse  out  1  one-cycle pulse: lock the current piece
- period_out  out  25  currently applied gravity period (registered)
- sched_state  out  2  current FSM state, for debug/display

Behaviour:
- Reset (async) and gamestate == GS_RESTART (4'd9, synchronous) both clear everything:
  - state = IDLE;
  - gravity counter, lock counter and resets_used = 0;
  - drop_tick = 0, lock_pulse = 0;
  - period_out = BASE_PERIOD.
- Effective period, computed combinationally each cycle:
  - eff = (scoremod + MIN_PERIOD < BASE_PERIOD) ? BASE_PERIOD - scoremod : MIN_PERIOD.
  - Compare in 26 bits so the sum cannot overflow.
  - If soft_drop && SOFT_PERIOD < eff, then per = SOFT_PERIOD; else per = eff.
  - period_out <= per every cycle, except while paused.
- Pause: gamestate is neither GS_PLAY nor GS_RESTART.
  - All counters, the state and resets_used hold.
  - drop_tick and lock_pulse are 0.
  - Resuming continues the count; the count does not restart.
- States:
  - IDLE: -> FALLING on the first cycle with gamestate == GS_PLAY. Gravity counter = 0.
  - FALLING:
    - gcnt increments each play cycle.
    - When gcnt >= per-1: next edge gcnt <= 0 and drop_tick <= 1 for one cycle. Ticks are therefore exactly per cycles apart.
    - Using >= means a period shrinking mid-count (score jump, soft_drop press) ticks on the next cycle and never wraps.
    - landed high -> LOCKING with lcnt = 0. On that transition cycle no drop_tick fires, even if gcnt would have expired (landed wins).
  - LOCKING:
    - Gravity is suppressed; lcnt increments.
    - piece_moved with resets_used < MAX_RESETS: lcnt <= 0, resets_used++.
    - piece_moved with resets_used == MAX_RESETS: ignored.
    - landed low (piece slid off an edge) -> FALLING with gcnt = 0; resets_used is kept.
    - lcnt >= LOCK_DELAY-1 and no honoured reset that cycle -> lock_pulse <= 1, state LOCKED.
    - A valid reset coinciding with expiry wins: no lock.
  - LOCKED: lasts exactly one cycle, then -> FALLING with gcnt = 0 and resets_used = 0 (new piece spawned).
- Latency:
  - drop_tick and lock_pulse are registered; they assert on the edge after the counter condition is met.
  - landed/piece_moved are sampled each edge; no input registering.
- Widths:
  - All counters are 25 bits.
  - resets_used is 4 bits and saturates at MAX_RESETS.

Decomposition:
- t01_game_pkg holds:
  - gamestate constants GS_PLAY = 4'd2 and GS_RESTART = 4'd9;
  - typedef enum logic [1:0] sched_state_t {IDLE, FALLING, LOCKING, LOCKED}.
- One sub-module, t01_period_calc (combinational): inputs scoremod, soft_drop; output per. It carries the clamp arithmetic.
- FSM and counters live in t01_drop_scheduler.

Test Plan (bench overrides BASE=100, MIN=20, SOFT=5, LOCK_DELAY=30, MAX_RESETS=3):
- Basic gravity: scoremod=0, GS_PLAY from reset release -> drop_tick every 100 cycles; period_out=100; sched_state=FALLING.
- Speed clamp: scoremod=50 -> ticks every 50. scoremod=90 -> period_out=20, ticks every 20. scoremod=25'h1FFFFFF -> still 20, no overflow.
- Soft drop mid-count: at gcnt=40 raise soft_drop -> tick next cycle, then every 5. soft_drop with scoremod=97 -> per=20 (SOFT only when smaller; here 5<20, so expect 5). Separately, SOFT=30 with per=20 -> stays 20.
- Lock delay with resets: landed at cycle T -> no drop_tick. piece_moved at lcnt=25 three times -> timer restarts each time. Fourth move ignored -> lock_pulse 30 cycles after the third reset. LOCKED for one cycle, then FALLING.
- Slide-off and collisions: landed drops in LOCKING -> FALLING with gcnt=0; next tick 100 cycles later. piece_moved on the expiry cycle with resets available -> no lock_pulse.
- Pause/restart: gamestate=4'd5 for 500 cycles at gcnt=60 -> no pulses, counters frozen; resume -> tick after 40 more cycles. gamestate=9 mid-LOCKING -> IDLE, all counters 0. Async reset mid-count -> outputs 0 immediately, period_out=100.
